// File: rtl/axioma_ac_pkg.sv
// Shared constants and types for the multi-channel analog comparator.
package axioma_ac_pkg;

  // Register offsets from ADDR_BASE
  localparam logic [5:0] OFF_ACSR   = 6'd0;
  localparam logic [5:0] OFF_ACMUX  = 6'd1;
  localparam logic [5:0] OFF_ACFILT = 6'd2;
  localparam logic [5:0] OFF_ACCNT  = 6'd3;

  // ACSR bit positions
  localparam int ACSR_ACD  = 7;
  localparam int ACSR_ACBG = 6;
  localparam int ACSR_ACO  = 5;
  localparam int ACSR_ACI  = 4;
  localparam int ACSR_ACIE = 3;
  localparam int ACSR_ACIC = 2;

  // ACMUX bit positions
  localparam int ACMUX_ACME = 7;

  localparam logic [7:0] ACCNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ACIS_TOGGLE = 2'b00,
    ACIS_RSVD   = 2'b01,
    ACIS_FALL   = 2'b10,
    ACIS_RISE   = 2'b11
  } acis_t;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_STARTUP  = 2'd1,
    ST_RUN      = 2'd2
  } ac_state_t;

  // True when an ACO transition matches the selected interrupt mode
  function automatic logic edge_qualified(input acis_t mode, input logic rise,
                                          input logic fall);
    case (mode)
      ACIS_TOGGLE: return rise | fall;
      ACIS_FALL:   return fall;
      ACIS_RISE:   return rise;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axioma_ac_filter.sv
// Glitch filter: owns the filter counter and the filtered ACO register.
// A raw level must differ from ACO for filt+1 consecutive cycles to be taken.
module axioma_ac_filter #(
  parameter int FILT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              raw_q,
  input  logic [FILT_W-1:0] filt,
  input  logic              clr,       // force ACO and counter to 0, no edge
  input  logic              fcnt_clr,  // restart the filter window only
  input  logic              load,      // take raw_q directly, no edge
  input  logic              en,        // normal filtering
  output logic              out,
  output logic              edge_rise,
  output logic              edge_fall
);

  localparam logic [FILT_W-1:0] FCNT_MAX = '1;

  logic [FILT_W-1:0] fcnt;
  logic              fire;

  assign fire      = en & ~fcnt_clr & (raw_q != out) & (fcnt == filt);
  assign edge_rise = fire & raw_q;
  assign edge_fall = fire & ~raw_q;

  // Filter counter and filtered output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out  <= 1'b0;
      fcnt <= '0;
    end else if (clr) begin
      out  <= 1'b0;
      fcnt <= '0;
    end else if (load) begin
      out  <= raw_q;
      fcnt <= '0;
    end else if (fire) begin
      out  <= raw_q;
      fcnt <= '0;
    end else if (!en || fcnt_clr || (raw_q == out)) begin
      fcnt <= '0;
    end else if (fcnt != FCNT_MAX) begin
      fcnt <= fcnt + 1'b1;
    end
  end

endmodule

// File: rtl/axioma_analog_comp_mc.sv
// Multi-channel analog comparator with synchronisers, startup sequencing,
// glitch filter, saturating event counter and input-capture trigger.
module axioma_analog_comp_mc
  import axioma_ac_pkg::*;
#(
  parameter int         N_CH        = 4,
  parameter int         FILT_W      = 4,
  parameter int         STARTUP_CYC = 15,
  parameter logic [5:0] ADDR_BASE   = 6'h10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ain0,
  input  logic            ain1,
  input  logic [N_CH-1:0] ain_n,
  input  logic            bandgap_in,
  input  logic [5:0]      io_addr,
  input  logic [7:0]      io_data_in,
  output logic [7:0]      io_data_out,
  input  logic            io_read,
  input  logic            io_write,
  output logic            analog_comp_interrupt,
  output logic            icp_trigger,
  output logic            debug_aco,
  output logic [1:0]      debug_state
);

  localparam int         SEL_BITS     = (N_CH > 1) ? $clog2(N_CH) : 0;
  localparam logic [2:0] SEL_MASK     = 3'((1 << SEL_BITS) - 1);
  localparam logic [7:0] STARTUP_LAST = 8'(STARTUP_CYC - 1);
  localparam logic [5:0] A_ACSR       = ADDR_BASE + OFF_ACSR;
  localparam logic [5:0] A_ACMUX      = ADDR_BASE + OFF_ACMUX;
  localparam logic [5:0] A_ACFILT     = ADDR_BASE + OFF_ACFILT;
  localparam logic [5:0] A_ACCNT      = ADDR_BASE + OFF_ACCNT;

  // Control/status registers
  logic              acd, acbg, aci, acie, acic, acme;
  acis_t             acis;
  logic [2:0]        sel;
  logic [FILT_W-1:0] filt;
  logic [7:0]        accnt;

  // Synchronised inputs, packed as {bandgap, ain1, ain0, ain_n}
  logic [N_CH+2:0] sync1, sync2;
  logic [N_CH-1:0] ain_n_s;
  logic            ain0_s, ain1_s, bg_s, chan_s;
  logic            pos, neg, raw_q;

  ac_state_t state, state_d;
  logic [7:0] startup_cnt, startup_cnt_d;
  logic       flt_clr, flt_load, flt_en;
  logic       aco, edge_rise, edge_fall, evt;

  logic wr_acsr, wr_acmux, wr_acfilt, wr_accnt, acd_next;

  assign wr_acsr   = io_write && (io_addr == A_ACSR);
  assign wr_acmux  = io_write && (io_addr == A_ACMUX);
  assign wr_acfilt = io_write && (io_addr == A_ACFILT);
  assign wr_accnt  = io_write && (io_addr == A_ACCNT);

  // A disable write takes effect on the same edge that stores it
  assign acd_next = wr_acsr ? io_data_in[ACSR_ACD] : acd;

  // Two-flop synchronisers on every analog-derived level
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep the two stages distinct flops;
    // a blocking '=' here would collapse the synchroniser to one stage.
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bandgap_in, ain1, ain0, ain_n};
      sync2 <= sync1;
    end
  end

  assign ain_n_s = sync2[N_CH-1:0];
  assign ain0_s  = sync2[N_CH];
  assign ain1_s  = sync2[N_CH+1];
  assign bg_s    = sync2[N_CH+2];

  // Negative-input channel mux; out-of-range selects read as 0
  always_comb begin
    // NOTE: default first so every path assigns chan_s and no latch is inferred.
    chan_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == 3'(i)) chan_s = ain_n_s[i];
    end
  end

  assign pos = acbg ? bg_s : ain0_s;
  assign neg = acme ? chan_s : ain1_s;

  // Comparator: decisive when operands differ, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             raw_q <= 1'b0;
    else if (pos && !neg)  raw_q <= 1'b1;
    else if (!pos && neg)  raw_q <= 1'b0;
  end

  // FSM state and startup counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_STARTUP;
      startup_cnt <= '0;
    end else begin
      state       <= state_d;
      startup_cnt <= startup_cnt_d;
    end
  end

  // FSM next-state and filter control
  always_comb begin
    state_d       = state;
    startup_cnt_d = startup_cnt;
    flt_clr       = 1'b0;
    flt_load      = 1'b0;
    flt_en        = 1'b0;
    if (acd_next) begin
      state_d       = ST_DISABLED;
      startup_cnt_d = '0;
      flt_clr       = 1'b1;
    end else begin
      case (state)
        ST_DISABLED: begin
          state_d       = ST_STARTUP;
          startup_cnt_d = '0;
          flt_clr       = 1'b1;
        end
        ST_STARTUP: begin
          if (startup_cnt == STARTUP_LAST) begin
            state_d       = ST_RUN;
            startup_cnt_d = '0;
            flt_load      = 1'b1;
          end else begin
            startup_cnt_d = startup_cnt + 8'd1;
            flt_clr       = 1'b1;
          end
        end
        ST_RUN: flt_en = 1'b1;
        default: begin
          state_d       = ST_DISABLED;
          startup_cnt_d = '0;
          flt_clr       = 1'b1;
        end
      endcase
    end
  end

  axioma_ac_filter #(.FILT_W(FILT_W)) u_filter (
    .clk       (clk),
    .reset     (reset),
    .raw_q     (raw_q),
    .filt      (filt),
    .clr       (flt_clr),
    .fcnt_clr  (wr_acmux | wr_acfilt),
    .load      (flt_load),
    .en        (flt_en),
    .out       (aco),
    .edge_rise (edge_rise),
    .edge_fall (edge_fall)
  );

  assign evt = edge_qualified(acis, edge_rise, edge_fall);

  // ACSR writable fields; ACO and ACI are not written directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acd  <= 1'b0;
      acbg <= 1'b0;
      acie <= 1'b0;
      acic <= 1'b0;
      acis <= ACIS_TOGGLE;
    end else if (wr_acsr) begin
      acd  <= io_data_in[ACSR_ACD];
      acbg <= io_data_in[ACSR_ACBG];
      acie <= io_data_in[ACSR_ACIE];
      acic <= io_data_in[ACSR_ACIC];
      acis <= acis_t'(io_data_in[1:0]);
    end
  end

  // Interrupt flag: a qualified edge beats a write-one-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                aci <= 1'b0;
    else if (evt)                             aci <= 1'b1;
    else if (wr_acsr && io_data_in[ACSR_ACI]) aci <= 1'b0;
  end

  // ACMUX and ACFILT registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acme <= 1'b0;
      sel  <= '0;
      filt <= '0;
    end else begin
      if (wr_acmux) begin
        acme <= io_data_in[ACMUX_ACME];
        sel  <= io_data_in[2:0] & SEL_MASK;
      end
      if (wr_acfilt) filt <= io_data_in[FILT_W-1:0];
    end
  end

  // Saturating event counter; clear-by-write still counts a coincident edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             accnt <= '0;
    else if (wr_accnt)                     accnt <= evt ? 8'd1 : 8'd0;
    else if (evt && (accnt != ACCNT_MAX))  accnt <= accnt + 8'd1;
  end

  // Combinational read mux
  always_comb begin
    io_data_out = '0;
    if (io_read) begin
      if (io_addr == A_ACSR)        io_data_out = {acd, acbg, aco, aci, acie, acic, acis};
      else if (io_addr == A_ACMUX)  io_data_out = {acme, 4'b0000, sel};
      else if (io_addr == A_ACFILT) io_data_out = 8'(filt);
      else if (io_addr == A_ACCNT)  io_data_out = accnt;
    end
  end

  assign analog_comp_interrupt = aci & acie;
  assign icp_trigger           = aco & acic;
  assign debug_aco             = aco;
  assign debug_state           = state;

endmodule

// File: tb/tb_axioma_analog_comp_mc.sv
// Directed, table-driven bench for axioma_analog_comp_mc.
module tb_axioma_analog_comp_mc;

  localparam int         N_CH     = 4;
  localparam logic [5:0] A_ACSR   = 6'h10;
  localparam logic [5:0] A_ACMUX  = 6'h11;
  localparam logic [5:0] A_ACFILT = 6'h12;
  localparam logic [5:0] A_ACCNT  = 6'h13;

  logic            clk = 1'b0;
  logic            reset;
  logic            ain0, ain1, bandgap_in;
  logic [N_CH-1:0] ain_n;
  logic [5:0]      io_addr;
  logic [7:0]      io_data_in, io_data_out;
  logic            io_read, io_write;
  logic            analog_comp_interrupt, icp_trigger, debug_aco;
  logic [1:0]      debug_state;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } reg_vec_t;

  typedef struct {
    logic acbg;
    logic a0;
    logic a1;
    logic bg;
    logic exp_aco;
  } cmp_vec_t;

  reg_vec_t   rv[6];
  cmp_vec_t   cv[9];
  logic [7:0] r;
  logic [7:0] exp_cnt;
  logic       prev_aco;

  always #5 clk = ~clk;

  axioma_analog_comp_mc #(
    .N_CH(N_CH), .FILT_W(4), .STARTUP_CYC(15), .ADDR_BASE(6'h10)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .ain0                  (ain0),
    .ain1                  (ain1),
    .ain_n                 (ain_n),
    .bandgap_in            (bandgap_in),
    .io_addr               (io_addr),
    .io_data_in            (io_data_in),
    .io_data_out           (io_data_out),
    .io_read               (io_read),
    .io_write              (io_write),
    .analog_comp_interrupt (analog_comp_interrupt),
    .icp_trigger           (icp_trigger),
    .debug_aco             (debug_aco),
    .debug_state           (debug_state)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Advance n edges, landing 1 ns after the last one
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    io_addr    = a;
    io_data_in = d;
    io_write   = 1'b1;
    tick();
    io_write   = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    io_addr = a;
    io_read = 1'b1;
    #1;
    d       = io_data_out;
    io_read = 1'b0;
  endtask

  // Drive a decisive comparator input: cmp follows a0
  task automatic set_in(input logic a0);
    ain0 = a0;
    ain1 = ~a0;
  endtask

  task automatic cnt_inc();
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
  endtask

  initial begin
    rv[0] = '{A_ACFILT, 8'hFF, 8'h0F};
    rv[1] = '{A_ACFILT, 8'h05, 8'h05};
    rv[2] = '{A_ACMUX,  8'hFF, 8'h83};
    rv[3] = '{A_ACMUX,  8'h06, 8'h02};
    rv[4] = '{A_ACMUX,  8'h00, 8'h00};
    rv[5] = '{A_ACFILT, 8'h00, 8'h00};

    cv[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cv[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cv[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    cv[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    cv[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    cv[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    cv[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; ain0 = 1'b1; ain1 = 1'b0; bandgap_in = 1'b0; ain_n = '0;
    io_addr = '0; io_data_in = '0; io_read = 1'b0; io_write = 1'b0;
    exp_cnt = 8'd0;

    // Reset state
    tick(3);
    check("rst_state", {6'b0, debug_state}, 8'd1);
    check_b("rst_aco", debug_aco, 1'b0);
    check_b("rst_irq", analog_comp_interrupt, 1'b0);
    check_b("rst_icp", icp_trigger, 1'b0);
    rd(A_ACSR, r);  check("rst_acsr", r, 8'h00);
    rd(A_ACCNT, r); check("rst_accnt", r, 8'h00);

    // Startup: 15 cycles in STARTUP, then RUN with ACO loaded
    reset = 1'b0;
    check("startup_state", {6'b0, debug_state}, 8'd1);
    for (int i = 0; i < 14; i++) begin
      tick();
      check("startup_state", {6'b0, debug_state}, 8'd1);
    end
    tick();
    check("run_state", {6'b0, debug_state}, 8'd2);
    check_b("run_entry_aco", debug_aco, 1'b1);
    rd(A_ACSR, r);  check("run_entry_acsr", r, 8'h20);
    rd(A_ACCNT, r); check("run_entry_accnt", r, 8'h00);

    // Register write/readback table
    for (int i = 0; i < 6; i++) begin
      wr(rv[i].addr, rv[i].wdata);
      rd(rv[i].addr, r);
      check("reg_readback", r, rv[i].exp);
    end

    // Rising-only interrupt, FILT=0 latency
    wr(A_ACSR, 8'h0B);
    rd(A_ACSR, r); check("acsr_0b", r, 8'h2B);
    set_in(1'b0);
    tick(4);
    check_b("fall_aco", debug_aco, 1'b0);
    check_b("fall_no_irq", analog_comp_interrupt, 1'b0);
    set_in(1'b1);
    tick(3);
    check_b("rise_k3_aco", debug_aco, 1'b0);
    tick();
    check_b("rise_k4_aco", debug_aco, 1'b1);
    check_b("rise_irq", analog_comp_interrupt, 1'b1);
    cnt_inc();
    rd(A_ACCNT, r); check("rise_accnt", r, exp_cnt);
    wr(A_ACSR, 8'h1B);
    check_b("aci_clear_irq", analog_comp_interrupt, 1'b0);
    rd(A_ACSR, r); check("aci_clear_acsr", r, 8'h2B);

    // Glitch filter FILT=3
    wr(A_ACFILT, 8'h03);
    set_in(1'b0);
    tick(3);
    set_in(1'b1);
    tick(10);
    check_b("glitch3_aco", debug_aco, 1'b1);
    rd(A_ACCNT, r); check("glitch3_accnt", r, exp_cnt);
    wr(A_ACSR, 8'h08);
    set_in(1'b0);
    tick(4);
    set_in(1'b1);
    tick(2);
    check_b("pulse4_k6_aco", debug_aco, 1'b1);
    tick();
    check_b("pulse4_k7_aco", debug_aco, 1'b0);
    check_b("pulse4_irq", analog_comp_interrupt, 1'b1);
    cnt_inc();
    tick(3);
    check_b("pulse4_k10_aco", debug_aco, 1'b0);
    tick();
    check_b("pulse4_k11_aco", debug_aco, 1'b1);
    cnt_inc();
    rd(A_ACCNT, r); check("pulse4_accnt", r, exp_cnt);
    wr(A_ACSR, 8'h18);

    // Muxed negative input, channel 2
    wr(A_ACFILT, 8'h00);
    wr(A_ACMUX, 8'h82);
    ain0 = 1'b0; ain_n = 4'b0100;
    tick(6);
    check_b("mux_ch2_high_aco", debug_aco, 1'b0);
    cnt_inc();
    ain_n = 4'b0000;
    tick(6);
    check_b("mux_equal_hold", debug_aco, 1'b0);
    ain0 = 1'b1;
    tick(6);
    check_b("mux_pos_high_aco", debug_aco, 1'b1);
    cnt_inc();
    ain0 = 1'b0; ain_n = 4'b1011;
    tick(6);
    check_b("mux_ignores_other_ch", debug_aco, 1'b1);
    wr(A_ACMUX, 8'h00);
    ain_n = 4'b0000;
    tick(4);

    // Operand selection table (ACIS=00, so every ACO change counts)
    prev_aco = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ain0 = cv[i].a0; ain1 = cv[i].a1; bandgap_in = cv[i].bg;
      wr(A_ACSR, {1'b0, cv[i].acbg, 6'b001000});
      tick(6);
      check_b("cmp_table_aco", debug_aco, cv[i].exp_aco);
      if (cv[i].exp_aco != prev_aco) cnt_inc();
      prev_aco = cv[i].exp_aco;
    end
    rd(A_ACCNT, r); check("cmp_table_accnt", r, exp_cnt);
    wr(A_ACSR, 8'h08);
    bandgap_in = 1'b0;

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      set_in(~ain0);
      tick(4);
      cnt_inc();
    end
    check_b("sat_aco", debug_aco, 1'b1);
    rd(A_ACCNT, r); check("accnt_saturated", r, 8'hFF);

    // ACCNT clear coincident with an edge -> 1
    set_in(1'b0);
    tick(3);
    wr(A_ACCNT, 8'h55);
    check_b("clr_edge_aco", debug_aco, 1'b0);
    rd(A_ACCNT, r); check("accnt_clear_with_edge", r, 8'h01);
    exp_cnt = 8'd1;

    // ACI set beats clear in the same cycle
    wr(A_ACSR, 8'h18);
    check_b("aci_cleared", analog_comp_interrupt, 1'b0);
    set_in(1'b1);
    tick(3);
    wr(A_ACSR, 8'h18);
    check_b("aci_set_wins", analog_comp_interrupt, 1'b1);
    cnt_inc();

    // Reserved ACIS=01: ACO moves, no event
    wr(A_ACSR, 8'h19);
    set_in(1'b0);
    tick(4);
    check_b("rsvd_aco", debug_aco, 1'b0);
    check_b("rsvd_no_irq", analog_comp_interrupt, 1'b0);
    rd(A_ACCNT, r); check("rsvd_accnt", r, exp_cnt);

    // ICP trigger and disable
    wr(A_ACSR, 8'h0C);
    set_in(1'b1);
    tick(4);
    cnt_inc();
    check_b("icp_high", icp_trigger, 1'b1);
    check_b("icp_irq", analog_comp_interrupt, 1'b1);
    wr(A_ACSR, 8'h8C);
    check("dis_state", {6'b0, debug_state}, 8'd0);
    check_b("dis_aco", debug_aco, 1'b0);
    check_b("dis_icp", icp_trigger, 1'b0);
    check_b("dis_irq_kept", analog_comp_interrupt, 1'b1);
    rd(A_ACSR, r);  check("dis_acsr", r, 8'h9C);
    rd(A_ACCNT, r); check("dis_accnt", r, exp_cnt);
    set_in(1'b0);
    tick(6);
    check_b("dis_aco_quiet", debug_aco, 1'b0);
    rd(A_ACCNT, r); check("dis_no_count", r, exp_cnt);

    // Re-enable: STARTUP for 15 cycles, load without an event
    wr(A_ACSR, 8'h0C);
    check("reen_state", {6'b0, debug_state}, 8'd1);
    tick(14);
    check("reen_still_startup", {6'b0, debug_state}, 8'd1);
    tick();
    check("reen_run", {6'b0, debug_state}, 8'd2);
    check_b("reen_aco", debug_aco, 1'b0);
    rd(A_ACCNT, r); check("reen_no_count", r, exp_cnt);
    set_in(1'b1);
    tick(4);
    check_b("reen_rise_aco", debug_aco, 1'b1);
    cnt_inc();
    rd(A_ACCNT, r); check("reen_accnt", r, exp_cnt);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    check("midrst_state", {6'b0, debug_state}, 8'd1);
    check_b("midrst_aco", debug_aco, 1'b0);
    check_b("midrst_irq", analog_comp_interrupt, 1'b0);
    check_b("midrst_icp", icp_trigger, 1'b0);
    rd(A_ACSR, r);  check("midrst_acsr", r, 8'h00);
    rd(A_ACCNT, r); check("midrst_accnt", r, 8'h00);
    tick(2);
    reset = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
